// File: rtl/insn_encoder.sv
// RV32I R/I-type encoder from ALU op requests, with a 2-entry output FIFO.
// Define INSN_ENC_X0_CHK_EN to reject rd=x0 requests other than the canonical NOP.
module insn_encoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic [3:0]  i_alu_op,
    input  logic        i_imm_sel,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [11:0] i_imm,
    output logic [31:0] o_insn,
    output logic        o_insn_vld,
    input  logic        i_insn_rdy,
    output logic        o_err,
    output logic [15:0] o_insn_cnt
);

    localparam logic [6:0]  OPC_R = 7'b0110011;
    localparam logic [6:0]  OPC_I = 7'b0010011;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [3:0]  OP_ADD = 4'd0;
    localparam logic [3:0]  OP_SUB = 4'd1;

    logic [1:0]       occ_q, occ_d;
    logic [1:0][31:0] mem_q, mem_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift;
    logic        op_ok;
    logic        x0_bad;
    logic        illegal;
    logic [31:0] word;
    logic        acc, enq, deq;

    always_comb begin
        f3       = 3'b000;
        f7       = 7'b0000000;
        is_shift = 1'b0;
        op_ok    = 1'b1;
        unique case (i_alu_op)
            4'd0: f3 = 3'b000;
            4'd1: begin
                f3 = 3'b000;
                f7 = 7'b0100000;
            end
            4'd2: f3 = 3'b010;
            4'd3: f3 = 3'b011;
            4'd4: f3 = 3'b100;
            4'd5: f3 = 3'b110;
            4'd6: f3 = 3'b111;
            4'd7: begin
                f3       = 3'b001;
                is_shift = 1'b1;
            end
            4'd8: begin
                f3       = 3'b101;
                is_shift = 1'b1;
            end
            4'd9: begin
                f3       = 3'b101;
                f7       = 7'b0100000;
                is_shift = 1'b1;
            end
            default: op_ok = 1'b0;
        endcase
    end

`ifdef INSN_ENC_X0_CHK_EN
    assign x0_bad = (i_rd == 5'd0) &
                    !((i_alu_op == OP_ADD) & i_imm_sel &
                      (i_rs1 == 5'd0) & (i_imm == 12'd0));
`else
    assign x0_bad = 1'b0;
`endif

    assign illegal = !op_ok | ((i_alu_op == OP_SUB) & i_imm_sel) | x0_bad;

    always_comb begin
        if (!i_imm_sel)
            word = {f7, i_rs2, i_rs1, f3, i_rd, OPC_R};
        else if (is_shift)
            word = {f7, i_imm[4:0], i_rs1, f3, i_rd, OPC_I};
        else
            word = {i_imm, i_rs1, f3, i_rd, OPC_I};
    end

    assign o_req_rdy  = (occ_q != 2'd2);
    assign o_insn_vld = (occ_q != 2'd0);
    assign o_insn     = o_insn_vld ? mem_q[0] : NOP;
    assign o_err      = err_q;
    assign o_insn_cnt = cnt_q;

    assign acc = i_req_vld & o_req_rdy;
    assign enq = acc & ~illegal;
    assign deq = o_insn_vld & i_insn_rdy;

    // Head always lives in slot 0; a write lands just behind the surviving entries.
    always_comb begin
        mem_d = mem_q;
        occ_d = occ_q + {1'b0, enq} - {1'b0, deq};
        err_d = acc & illegal;
        cnt_d = deq ? cnt_q + 16'd1 : cnt_q;
        if (deq)
            mem_d[0] = mem_q[1];
        if (enq) begin
            if ((occ_q == 2'd1) && !deq)
                mem_d[1] = word;
            else
                mem_d[0] = word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ_q <= 2'd0;
            mem_q <= '0;
            err_q <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            occ_q <= occ_d;
            mem_q <= mem_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
